// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller for the BCD ALU: builds sign-magnitude BCD operands from key
// presses, loads them onto the ALU bus (op1, then op2), then holds the ALU enabled for the result.
module calc_entry_ctrl #(
    parameter int DIGITS = 2,               // must be >= 2
    parameter int OPW    = 4*DIGITS + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_valid,
    input  logic [3:0]     key_code,
    input  logic [OPW-1:0] alu_result,
    output logic [OPW-1:0] op,
    output logic           assign_op1,
    output logic           assign_op2,
    output logic [2:0]     opcode,
    output logic           alu_en,
    output logic           busy,
    output logic [OPW-1:0] disp_val
);
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {ENT1, OPR, ENT2, LD1, LD2, RES} state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [2:0]     opcode_q, opcode_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           is_digit, is_arith;
    logic [2:0]     key_opcode;
    logic           room;

    function automatic logic [OPW-1:0] shift_in(input logic [OPW-1:0] v, input logic [3:0] d);
        return {v[OPW-1], v[4*DIGITS-5:0], d};
    endfunction

    // A zero magnitude keeps its positive sign so -0 never appears.
    function automatic logic [OPW-1:0] toggle_sign(input logic [OPW-1:0] v);
        return (|v[OPW-2:0]) ? {~v[OPW-1], v[OPW-2:0]} : v;
    endfunction

    assign is_digit   = key_code < 4'd10;
    assign is_arith   = (key_code == 4'hA) || (key_code == 4'hB);
    assign key_opcode = (key_code == 4'hA) ? 3'b001 : 3'b010;
    assign room       = cnt_q < CW'(DIGITS);

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        opcode_d = opcode_q;
        cnt_d    = cnt_q;
        case (state_q)
            LD1: state_d = LD2;
            LD2: state_d = RES;
            default: begin
                if (key_valid && key_code == 4'hD) begin
                    state_d  = ENT1;
                    op1_d    = '0;
                    op2_d    = '0;
                    opcode_d = '0;
                    cnt_d    = '0;
                end else if (key_valid) begin
                    case (state_q)
                        ENT1: begin
                            if (is_digit && room) begin
                                op1_d = shift_in(op1_q, key_code);
                                cnt_d = cnt_q + 1'b1;
                            end else if (key_code == 4'hE) begin
                                op1_d = toggle_sign(op1_q);
                            end else if (is_arith) begin
                                opcode_d = key_opcode;
                                cnt_d    = '0;
                                state_d  = OPR;
                            end
                        end
                        OPR: begin
                            if (is_digit) begin
                                op2_d   = {{(OPW-4){1'b0}}, key_code};
                                cnt_d   = CW'(1);
                                state_d = ENT2;
                            end else if (is_arith) begin
                                opcode_d = key_opcode;
                            end
                        end
                        ENT2: begin
                            if (is_digit && room) begin
                                op2_d = shift_in(op2_q, key_code);
                                cnt_d = cnt_q + 1'b1;
                            end else if (key_code == 4'hE) begin
                                op2_d = toggle_sign(op2_q);
                            end else if (key_code == 4'hC) begin
                                state_d = LD1;
                            end
                        end
                        RES: begin
                            if (is_digit) begin
                                op1_d    = {{(OPW-4){1'b0}}, key_code};
                                op2_d    = '0;
                                opcode_d = '0;
                                cnt_d    = CW'(1);
                                state_d  = ENT1;
                            end else if (is_arith) begin
                                op1_d    = alu_result;
                                op2_d    = '0;
                                opcode_d = key_opcode;
                                cnt_d    = '0;
                                state_d  = OPR;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ENT1;
            op1_q    <= '0;
            op2_q    <= '0;
            opcode_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs depend only on registered state, plus the ALU's own result while in RES.
    always_comb begin
        op         = '0;
        assign_op1 = 1'b0;
        assign_op2 = 1'b0;
        alu_en     = 1'b0;
        busy       = 1'b0;
        disp_val   = op1_q;
        opcode     = opcode_q;
        case (state_q)
            ENT2: disp_val = op2_q;
            LD1: begin
                op         = op1_q;
                assign_op1 = 1'b1;
                busy       = 1'b1;
                disp_val   = op2_q;
            end
            LD2: begin
                op         = op2_q;
                assign_op2 = 1'b1;
                busy       = 1'b1;
                disp_val   = op2_q;
            end
            RES: begin
                alu_en   = 1'b1;
                disp_val = alu_result;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed scenarios plus random key streams, all checked
// against a decimal-arithmetic model of the calculator entry flow.
module tb_calc_entry_ctrl;
    localparam int DIGITS = 2;
    localparam int OPW    = 4*DIGITS + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           key_valid = 1'b0;
    logic [3:0]     key_code = '0;
    logic [OPW-1:0] alu_result = '0;
    logic [OPW-1:0] op, disp_val;
    logic           assign_op1, assign_op2, alu_en, busy;
    logic [2:0]     opcode;

    int nchk = 0;
    int nfail = 0;

    calc_entry_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .alu_result(alu_result), .op(op), .assign_op1(assign_op1),
        .assign_op2(assign_op2), .opcode(opcode), .alu_en(alu_en),
        .busy(busy), .disp_val(disp_val)
    );

    always #5 clk = ~clk;

    // Model: phase names the calculator step; operands held as sign + decimal magnitude in BCD form.
    localparam int P_ENT1 = 0, P_OPR = 1, P_ENT2 = 2, P_LD1 = 3, P_LD2 = 4, P_RES = 5;
    int             ph = P_ENT1;
    int             ndig = 0;
    logic [OPW-1:0] m_op1 = '0, m_op2 = '0;
    logic [2:0]     m_opc = '0;

    function automatic int mag(input logic [OPW-1:0] v);
        int m = 0;
        for (int i = DIGITS - 1; i >= 0; i--) m = m * 10 + int'(v[4*i +: 4]);
        return m;
    endfunction

    function automatic logic [OPW-1:0] bcd(input logic s, input int m);
        logic [OPW-1:0] v = '0;
        int x = m;
        v[OPW-1] = s;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction

    function automatic logic [OPW-1:0] add_digit(input logic [OPW-1:0] v, input int d);
        return bcd(v[OPW-1], mag(v) * 10 + d);
    endfunction

    function automatic logic [OPW-1:0] flip(input logic [OPW-1:0] v);
        if (mag(v) == 0) return v;
        return bcd(~v[OPW-1], mag(v));
    endfunction

    task automatic model_clear();
        ph = P_ENT1; ndig = 0; m_op1 = '0; m_op2 = '0; m_opc = '0;
    endtask

    task automatic model_step(input logic r, input logic v, input logic [3:0] k);
        int d = int'(k);
        logic arith = (k == 4'hA) || (k == 4'hB);
        logic [2:0] kop = (k == 4'hA) ? 3'b001 : 3'b010;
        if (r) model_clear();
        else if (ph == P_LD1) ph = P_LD2;
        else if (ph == P_LD2) ph = P_RES;
        else if (v && k == 4'hD) model_clear();
        else if (v) begin
            case (ph)
                P_ENT1:
                    if (d < 10) begin
                        if (ndig < DIGITS) begin m_op1 = add_digit(m_op1, d); ndig++; end
                    end else if (k == 4'hE) m_op1 = flip(m_op1);
                    else if (arith) begin m_opc = kop; ndig = 0; ph = P_OPR; end
                P_OPR:
                    if (d < 10) begin m_op2 = bcd(1'b0, d); ndig = 1; ph = P_ENT2; end
                    else if (arith) m_opc = kop;
                P_ENT2:
                    if (d < 10) begin
                        if (ndig < DIGITS) begin m_op2 = add_digit(m_op2, d); ndig++; end
                    end else if (k == 4'hE) m_op2 = flip(m_op2);
                    else if (k == 4'hC) ph = P_LD1;
                P_RES:
                    if (d < 10) begin
                        m_op1 = bcd(1'b0, d); m_op2 = '0; m_opc = '0; ndig = 1; ph = P_ENT1;
                    end else if (arith) begin
                        m_op1 = alu_result; m_op2 = '0; m_opc = kop; ndig = 0; ph = P_OPR;
                    end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [OPW-1:0] got, input logic [OPW-1:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("op", op, (ph == P_LD1) ? m_op1 : (ph == P_LD2) ? m_op2 : '0);
        chk("assign_op1", OPW'(assign_op1), OPW'(ph == P_LD1));
        chk("assign_op2", OPW'(assign_op2), OPW'(ph == P_LD2));
        chk("busy", OPW'(busy), OPW'(ph == P_LD1 || ph == P_LD2));
        chk("alu_en", OPW'(alu_en), OPW'(ph == P_RES));
        chk("opcode", OPW'(opcode), OPW'(m_opc));
        chk("disp_val", disp_val,
            (ph == P_RES) ? alu_result : (ph <= P_OPR) ? m_op1 : m_op2);
    endtask

    task automatic cycle(input logic r, input logic v, input logic [3:0] k);
        rst = r; key_valid = v; key_code = k;
        @(posedge clk);
        model_step(r, v, k);
        #1;
        check_outputs();
        rst = 1'b0; key_valid = 1'b0; key_code = '0;
    endtask

    task automatic press(input logic [3:0] k);
        cycle(1'b0, 1'b1, k);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        logic [OPW-1:0] rnd;
        cycle(1'b1, 1'b0, 4'h0);

        // Reset while mid-entry in ENT2 returns everything to zero
        press(4'h1); press(4'hA); press(4'h2);
        cycle(1'b1, 1'b0, 4'h0); cycle(1'b1, 1'b0, 4'h0);
        chk("reset_disp", disp_val, 9'h000);
        chk("reset_opcode", OPW'(opcode), 9'h000);
        press(4'h3);
        chk("reset_back_to_ent1", disp_val, 9'h003);
        press(4'hD);

        // Third digit is dropped
        press(4'h4); press(4'h2); press(4'h7);
        chk("digit_limit", disp_val, 9'h042);

        // Full add load sequence
        press(4'hD);
        press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4);
        alu_result = 9'h046;
        press(4'hC);
        chk("ld1_op", op, 9'h012);
        idle();
        chk("ld2_op", op, 9'h034);
        idle();
        chk("res_alu_en", OPW'(alu_en), 9'h001);
        chk("res_opcode", OPW'(opcode), 9'h001);
        chk("res_disp", disp_val, 9'h046);

        // Chaining from a result
        press(4'hD);
        press(4'h5); press(4'hB); press(4'h9); press(4'hC); idle(); idle();
        alu_result = 9'h104;
        press(4'hA);
        chk("chain_op1", disp_val, 9'h104);
        chk("chain_opcode", OPW'(opcode), 9'h001);

        // Sign toggle, no negative zero
        press(4'hD);
        press(4'hE);
        chk("no_neg_zero", disp_val, 9'h000);
        press(4'h5); press(4'hE);
        chk("neg_five", disp_val, 9'h105);
        press(4'hE);
        chk("pos_five", disp_val, 9'h005);

        // Keys while busy are dropped
        press(4'hD);
        press(4'h1); press(4'hA); press(4'h2); press(4'hC);
        press(4'h3);
        chk("busy_drop_op2", op, 9'h002);
        idle();
        chk("busy_drop_res", OPW'(alu_en), 9'h001);
        press(4'hF);

        // Random key streams against the model
        for (int i = 0; i < 3000; i++) begin
            rnd = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            alu_result = rnd;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
